// File: rtl/fft_pkg.sv
// Shared constants, types and the square helper for the FFT magnitude writer.
package fft_pkg;
  localparam int NBINS = 1024;
  localparam int AW    = 10;
  localparam int IW    = 14;
  localparam int MW    = 28;

  typedef logic [MW-1:0] mag_t;
  typedef logic [AW-1:0] bin_t;

  typedef enum logic [1:0] {IDLE, WRITE, DRAIN, DONE} wr_state_t;

  localparam bin_t LAST_BIN = bin_t'(NBINS - 1);

  // Square of a signed IW-bit value; the true result is at most 2^26, so the
  // low MW bits of the sign-extended product are exact.
  function automatic mag_t sq(input logic [IW-1:0] x);
    mag_t xw;
    xw = {{(MW-IW){x[IW-1]}}, x};
    return xw * xw;
  endfunction
endpackage

// File: rtl/mag_sq.sv
// Two-stage re^2 + im^2 with valid/address sideband; latency 2 cycles.
// Free-running: bubbles travel through as out_valid=0, no backpressure.
module mag_sq
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [IW-1:0] re,
  input  logic [IW-1:0] im,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [MW-1:0] mag
);

  logic          v1;
  logic [AW-1:0] a1;
  mag_t          sq_re;
  mag_t          sq_im;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      a1        <= '0;
      sq_re     <= '0;
      sq_im     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      mag       <= '0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
      if (in_valid) begin
        a1    <= in_addr;
        sq_re <= sq(re);
        sq_im <= sq(im);
      end
      if (v1) begin
        out_addr <= a1;
        mag      <= sq_re + sq_im;
      end
    end
  end

endmodule

// File: rtl/fft_magwriter.sv
// Writes |X[k]|^2 of each FFT bin into FFT_RAM, then holds fftdone until detectdone.
// Latency 2 cycles accept->wren; sink_ready low in DRAIN/DONE; FFTW_HALF_SPECTRUM_EN writes lower half only.
module fft_magwriter
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          sink_valid,
  output logic          sink_ready,
  input  logic          sink_sop,
  input  logic          sink_eop,
  input  logic [IW-1:0] sink_real,
  input  logic [IW-1:0] sink_imag,
  output logic [AW-1:0] wraddr,
  output logic [MW-1:0] data,
  output logic          wren,
  output logic          fftdone,
  input  logic          detectdone,
  output logic          frame_err
);

  wr_state_t state, state_nxt;
  bin_t      count, count_nxt;
  bin_t      pipe_addr;
  logic      pipe_vld;
  logic      err_nxt;
  logic      drain_dly;
  logic      accept;
  logic      out_valid;

  assign accept  = sink_valid & sink_ready;
  assign fftdone = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      drain_dly  <= 1'b0;
      frame_err  <= 1'b0;
      sink_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      drain_dly  <= (state == DRAIN);
      frame_err  <= err_nxt;
      sink_ready <= (state_nxt == IDLE) || (state_nxt == WRITE);
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    err_nxt   = 1'b0;
    pipe_vld  = 1'b0;
    pipe_addr = count;
    case (state)
      IDLE: begin
        if (accept && sink_sop) begin
          pipe_vld  = 1'b1;
          pipe_addr = '0;
          count_nxt = bin_t'(1);
          state_nxt = WRITE;
          if (sink_eop) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WRITE: begin
        if (accept) begin
          pipe_vld = 1'b1;
          if (sink_sop) begin
            // restart: this sample becomes bin 0 of a fresh frame
            err_nxt   = 1'b1;
            pipe_addr = '0;
            count_nxt = bin_t'(1);
            if (sink_eop) state_nxt = IDLE;
          end else if (count == LAST_BIN) begin
            err_nxt   = ~sink_eop;
            state_nxt = sink_eop ? DRAIN : IDLE;
          end else if (sink_eop) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            count_nxt = count + bin_t'(1);
          end
        end
      end
      DRAIN: begin
        // eop sample reaches wren one cycle after entry; leave right behind it
        if (drain_dly) state_nxt = DONE;
      end
      DONE: begin
        if (detectdone) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mag_sq u_mag_sq (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pipe_vld),
    .in_addr   (pipe_addr),
    .re        (sink_real),
    .im        (sink_imag),
    .out_valid (out_valid),
    .out_addr  (wraddr),
    .mag       (data)
  );

`ifdef FFTW_HALF_SPECTRUM_EN
  assign wren = out_valid & ~wraddr[AW-1];
`else
  assign wren = out_valid;
`endif

endmodule

// File: tb/tb_fft_magwriter.sv
// Random-stimulus bench for fft_magwriter with a sample-level framing model and RAM/freqdetect stand-ins.
module tb_fft_magwriter;
  import fft_pkg::*;

`ifdef FFTW_HALF_SPECTRUM_EN
  localparam int NWR = NBINS / 2;
`else
  localparam int NWR = NBINS;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sink_valid = 1'b0;
  logic          sink_sop = 1'b0;
  logic          sink_eop = 1'b0;
  logic [IW-1:0] sink_real = '0;
  logic [IW-1:0] sink_imag = '0;
  logic          detectdone = 1'b0;
  logic          sink_ready;
  logic [AW-1:0] wraddr;
  logic [MW-1:0] data;
  logic          wren;
  logic          fftdone;
  logic          frame_err;

  fft_magwriter dut (
    .clk        (clk),
    .reset      (reset),
    .sink_valid (sink_valid),
    .sink_ready (sink_ready),
    .sink_sop   (sink_sop),
    .sink_eop   (sink_eop),
    .sink_real  (sink_real),
    .sink_imag  (sink_imag),
    .wraddr     (wraddr),
    .data       (data),
    .wren       (wren),
    .fftdone    (fftdone),
    .detectdone (detectdone),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     addr;
    longint dat;
    longint cyc;
  } exp_t;

  exp_t   expq[$];
  longint ram[NBINS];
  longint cyc = 0;
  longint exp_done_cyc = -1;
  int     assert_cnt = 0;
  int     fail_cnt = 0;
  int     wr_total = 0;
  int     err_seen = 0;
  int     err_exp = 0;
  bit     m_active = 1'b0;
  int     m_bin = 0;
  bit     prev_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sval(input logic [IW-1:0] v);
    return v[IW-1] ? int'(v) - (1 << IW) : int'(v);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model, RAM image and freqdetect-side observation.
  always @(negedge clk) begin
    exp_t e;
    bit   err;
    int   r, i;
    if (reset) begin
      expq.delete();
      m_active     = 1'b0;
      m_bin        = 0;
      exp_done_cyc = -1;
      prev_done    = 1'b0;
    end else begin
      if (wren) begin
        wr_total++;
        if (expq.size() == 0) begin
          check("wren_unexpected", wren, 0);
        end else begin
          e = expq.pop_front();
          check("wraddr", wraddr, e.addr);
          check("data", data, e.dat);
          check("wren_latency", cyc, e.cyc);
        end
        ram[wraddr] = data;
      end
      if (frame_err) err_seen++;
      if (fftdone && !prev_done) check("fftdone_rise", cyc, exp_done_cyc);
      prev_done = fftdone;
      if (sink_valid && sink_ready) begin
        err = 1'b0;
        if (sink_sop) begin
          err      = m_active;
          m_bin    = 0;
          m_active = 1'b1;
        end
        if (m_active) begin
          r = sval(sink_real);
          i = sval(sink_imag);
          if (m_bin < NWR)
            expq.push_back('{addr: m_bin, dat: longint'(r*r + i*i), cyc: cyc + 2});
          if (m_bin == NBINS - 1) begin
            if (sink_eop) exp_done_cyc = cyc + 3;
            else err = 1'b1;
            m_active = 1'b0;
          end else if (sink_eop) begin
            err      = 1'b1;
            m_active = 1'b0;
          end else begin
            m_bin++;
          end
        end
        if (err) err_exp++;
      end
    end
  end

  task automatic send_sample(input logic [IW-1:0] re, input logic [IW-1:0] im,
                             input logic sop, input logic eop, input int gap);
    int n;
    if ($urandom_range(0, 99) < gap) begin
      sink_valid = 1'b0;
      @(posedge clk); #1;
    end
    sink_valid = 1'b1;
    sink_real  = re;
    sink_imag  = im;
    sink_sop   = sop;
    sink_eop   = eop;
    n = 0;
    @(negedge clk);
    while (!sink_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sink_ready) check("ready_timeout", sink_ready, 1);
    @(posedge clk); #1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  // mode 0: 3-4j everywhere, 100 at bin 0xCC; 1: random; 2: extremes at 0..2 then random
  task automatic send_frame(input int mode, input int n, input int sop2, input int eop_pos, input int gap);
    logic [IW-1:0] re, im;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      re = IW'($urandom_range(0, (1 << IW) - 1));
      im = IW'($urandom_range(0, (1 << IW) - 1));
      if (mode == 0) begin
        re = (k == 'hCC) ? IW'(100) : IW'(3);
        im = (k == 'hCC) ? IW'(0) : 14'h3FFC;
      end else if (mode == 2 && k < 3) begin
        re = (k == 0) ? 14'h2000 : (k == 1) ? 14'h1FFF : 14'h0000;
        im = (k == 0) ? 14'h2000 : 14'h0000;
      end
      send_sample(re, im, (k == 0) || (k == sop2), k == eop_pos, gap);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 4000 && fftdone !== 1'b1; i++) @(negedge clk);
    check(tag, fftdone, 1);
  endtask

  task automatic release_done();
    @(posedge clk); #1;
    detectdone = 1'b1;
    @(posedge clk); #1;
    detectdone = 1'b0;
    check("fftdone_release", fftdone, 0);
    check("ready_after_done", sink_ready, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, sink_ready, 0);
    check({tag, "_wren"}, wren, 0);
    check({tag, "_wraddr"}, wraddr, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_fftdone"}, fftdone, 0);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    int w0, e0, busy, mb;
    longint mv;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", sink_ready, 1);

    // clean frame with a single peak
    w0 = wr_total;
    send_frame(0, NBINS, -1, NBINS - 1, 0);
    wait_done("done_full");
    check("writes_full", wr_total - w0, NWR);
    check("ram_cc", ram['hCC], 10000);
    check("ram_5", ram[5], 25);
    check("ram_top", ram[NWR-1], 25);
    mb = 0;
    mv = -1;
    for (int k = 0; k < NWR; k++) if (ram[k] > mv) begin mv = ram[k]; mb = k; end
    check("maxbin", mb, 'hCC);

    // sink must stay closed while the result is held
    busy = 0;
    @(posedge clk); #1;
    sink_valid = 1'b1;
    sink_sop   = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (sink_ready || wren) busy++;
    end
    @(posedge clk); #1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    check("busy_in_done", busy, 0);
    check("done_held", fftdone, 1);
    release_done();

    // framing errors
    e0 = err_seen;
    send_frame(1, 501, -1, 500, 0);
    repeat (8) @(negedge clk);
    check("err_eop500", err_seen - e0, 1);
    check("no_done_eop500", fftdone, 0);

    e0 = err_seen;
    send_frame(1, NBINS, -1, -1, 0);
    repeat (8) @(negedge clk);
    check("err_no_eop", err_seen - e0, 1);
    check("no_done_no_eop", fftdone, 0);

    e0 = err_seen;
    send_frame(1, NBINS + 300, 300, NBINS + 299, 10);
    wait_done("done_after_restart");
    check("err_sop300", err_seen - e0, 1);
    release_done();
    check("err_total", err_seen, err_exp);

    // extremes inside a frame with ~30% valid gaps
    w0 = wr_total;
    send_frame(2, NBINS, -1, NBINS - 1, 30);
    wait_done("done_gaps");
    check("writes_gaps", wr_total - w0, NWR);
    check("ram_neg_max", ram[0], 'h8000000);
    check("ram_pos_max", ram[1], 'h3FFC001);
    check("ram_zero", ram[2], 0);
    release_done();

    // asynchronous reset mid-frame
    send_frame(1, 600, -1, -1, 0);
    #1 reset = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    w0 = wr_total;
    send_frame(1, NBINS, -1, NBINS - 1, 0);
    wait_done("done_after_rst");
    check("writes_after_rst", wr_total - w0, NWR);
    release_done();
    repeat (5) @(negedge clk);
    check("queue_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
